// File: rtl/dmem_pkg.sv
// Shared encodings for the dmem_sync data memory: access sizes, controller
// states and the alignment rule shared by the top and the lane aligner.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // An illegal size counts as misaligned so the caller needs one fault term.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and shifted data for stores,
// byte/half extraction with sign or zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_shifted,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_shifted = st_data << {lane, 3'b000};
        ld_shifted = ld_word >> {lane, 3'b000};
        st_be      = 4'b0000;
        ld_data    = ld_word;
        case (size)
            SZ_BYTE: begin
                st_be   = 4'b0001 << lane;
                ld_data = is_unsigned ? {24'h000000, ld_shifted[7:0]}
                                      : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            end
            SZ_HALF: begin
                st_be   = 4'b0011 << lane;
                ld_data = is_unsigned ? {16'h0000, ld_shifted[15:0]}
                                      : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            end
            SZ_WORD: begin
                st_be   = 4'b1111;
                ld_data = ld_word;
            end
            default: begin
                st_be   = 4'b0000;
                ld_data = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_sync.sv
// Single-ported synchronous data memory with byte/half/word access, fault
// detection and an optional post-reset zero-fill sweep.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DEPTH          = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h0000_3000),
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int                  IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(DEPTH * 4);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               in_range;
    logic               fault;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        rd_word;
    logic [3:0]         st_be;
    logic [31:0]        st_shifted;
    logic [31:0]        ld_data;
    logic [31:0]        merged;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [31:0]        mem_wdata;

    assign req_ready = (state_q == ST_READY);
    assign accept    = req_valid && req_ready && rst_n;

    // Compare with one extra bit so a window ending at the top of the
    // address space cannot wrap.
    assign in_range = ({1'b0, req_addr} >= BASE_EXT) && ({1'b0, req_addr} < LIMIT_EXT);
    assign fault    = !in_range || misaligned(req_size, req_addr[1:0]);
    assign offset   = req_addr - BASE_ADDR;
    assign req_idx  = IDX_W'(offset >> 2);

    // The single read port serves both load data and the store merge.
    assign rd_word = mem[req_idx];

    dmem_lane_align u_lane_align (
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .st_data     (req_wdata),
        .ld_word     (rd_word),
        .st_be       (st_be),
        .st_shifted  (st_shifted),
        .ld_data     (ld_data)
    );

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = st_be[b] ? st_shifted[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        mem_widx    = clr_idx_q;
        mem_wdata   = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_READY: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    if (fault) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (req_write) begin
                        mem_we      = 1'b1;
                        mem_widx    = req_idx;
                        mem_wdata   = merged;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        rsp_rdata_d = ld_data;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The array itself is never reset; only the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync (DEPTH=16): vector table plus scoreboard,
// with hand-written reset and clear-restart sequences.
module tb_dmem_sync;
    import dmem_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_sync #(
        .ADDR_WIDTH     (32),
        .DEPTH          (DEPTH),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Every response pulse must match the oldest outstanding request and
    // arrive in the cycle right after it was accepted.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding, expected 0", rsp_valid);
            end else begin
                e = sb.pop_front();
                check_output({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check_output({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                check_output({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic apply_stimulus(input string name, input logic wr, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   waited = 0;
        while (req_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            $display("[TB] FAIL %s_ready: req_ready=%b, expected 1 within 100 cycles", name, req_ready);
            return;
        end
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + 1;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({name, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // One reset edge, optionally with a store presented that must be dropped.
    task automatic reset_pulse(input string name, input logic with_req);
        rst_n     = 1'b0;
        req_valid = with_req;
        req_write = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = BASE + 32'h8;
        req_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        check_output({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_output({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check_output({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    task automatic measure_clear(input string name);
        int busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            busy++;
        end
        check_output({name, "_clear_cycles"}, 32'(busy), 32'(DEPTH));
    endtask

    task automatic fill_pattern(input logic [31:0] tag);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus("fill", 1'b1, SZ_WORD, 1'b0, BASE + 32'(4 * i), tag | 32'(i), 32'h0, 1'b0);
        end
        apply_stimulus("fill_rd", 1'b0, SZ_WORD, 1'b0, BASE + 32'h14, 32'h0, tag | 32'h5, 1'b0);
        drain("fill");
    endtask

    task automatic expect_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(name, 1'b0, SZ_WORD, 1'b0, BASE + 32'(4 * i), 32'h0, 32'h0, 1'b0);
        end
        drain(name);
    endtask

    task automatic add(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input logic err);
        vec_t v;
        v.name = name; v.wr = wr; v.sz = sz; v.uns = uns;
        v.addr = addr; v.wd = wd; v.rd = rd; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = BASE;
        req_wdata    = 32'h0;

        add("sw_beef",   1'b1, SZ_WORD, 1'b0, 32'h3004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        add("lb_s_3007", 1'b0, SZ_BYTE, 1'b0, 32'h3007, 32'h0,         32'hFFFF_FFDE, 1'b0);
        add("lbu_3004",  1'b0, SZ_BYTE, 1'b1, 32'h3004, 32'h0,         32'h0000_00EF, 1'b0);
        add("lh_s_3004", 1'b0, SZ_HALF, 1'b0, 32'h3004, 32'h0,         32'hFFFF_BEEF, 1'b0);
        add("lhu_3006",  1'b0, SZ_HALF, 1'b1, 32'h3006, 32'h0,         32'h0000_DEAD, 1'b0);
        add("sh_3006",   1'b1, SZ_HALF, 1'b0, 32'h3006, 32'hABCD_1234, 32'h0000_0000, 1'b0);
        add("lw_merged", 1'b0, SZ_WORD, 1'b0, 32'h3004, 32'h0,         32'h1234_BEEF, 1'b0);
        add("lh_s_3006", 1'b0, SZ_HALF, 1'b0, 32'h3006, 32'h0,         32'h0000_1234, 1'b0);
        add("lw_misal",  1'b0, SZ_WORD, 1'b0, 32'h3002, 32'h0,         32'h0000_0000, 1'b1);
        add("sw_below",  1'b1, SZ_WORD, 1'b0, 32'h2FFC, 32'h5555_5555, 32'h0000_0000, 1'b1);
        add("sw_size11", 1'b1, 2'b11,   1'b0, 32'h3004, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add("sh_misal",  1'b1, SZ_HALF, 1'b0, 32'h3005, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
        add("sw_above",  1'b1, SZ_WORD, 1'b0, 32'h3040, 32'h1111_1111, 32'h0000_0000, 1'b1);
        add("lw_intact", 1'b0, SZ_WORD, 1'b0, 32'h3004, 32'h0,         32'h1234_BEEF, 1'b0);
        add("ld_size11", 1'b0, 2'b11,   1'b0, 32'h3004, 32'h0,         32'h0000_0000, 1'b1);
        add("sb_303f",   1'b1, SZ_BYTE, 1'b0, 32'h303F, 32'h1234_5680, 32'h0000_0000, 1'b0);
        add("lb_s_303f", 1'b0, SZ_BYTE, 1'b0, 32'h303F, 32'h0,         32'hFFFF_FF80, 1'b0);
        add("sb_3009",   1'b1, SZ_BYTE, 1'b0, 32'h3009, 32'h0000_007F, 32'h0000_0000, 1'b0);
        add("lb_s_3009", 1'b0, SZ_BYTE, 1'b0, 32'h3009, 32'h0,         32'h0000_007F, 1'b0);
        add("lhu_3008",  1'b0, SZ_HALF, 1'b1, 32'h3008, 32'h0,         32'h0000_7F00, 1'b0);
        add("sw_3008",   1'b1, SZ_WORD, 1'b0, 32'h3008, 32'h0102_0304, 32'h0000_0000, 1'b0);
        add("lh_s_300a", 1'b0, SZ_HALF, 1'b0, 32'h300A, 32'h0,         32'h0000_0102, 1'b0);
        add("lbu_300a",  1'b0, SZ_BYTE, 1'b1, 32'h300A, 32'h0,         32'h0000_0002, 1'b0);
        add("lw_last",   1'b0, SZ_WORD, 1'b0, 32'h303C, 32'h0,         32'h8000_0000, 1'b0);

        // Power-on reset, then overwrite everything so the next clear is observable.
        reset_pulse("por", 1'b0);
        measure_clear("por");
        fill_pattern(32'hC0DE_0000);

        // Reset with a store presented in the reset cycle; it must vanish.
        reset_pulse("rst_req", 1'b1);
        measure_clear("rst_req");
        expect_all_zero("clr_rd");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].uns,
                           vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].err);
        end
        drain("table");

        // Inputs toggling with req_valid low must neither write nor disturb outputs.
        req_write = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 32'h3004;
        req_wdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            req_addr = req_addr + 32'h4;
        end
        check_output("hold_rdata", rsp_rdata, 32'h8000_0000);
        check_output("hold_err", 32'(rsp_err), 32'd0);
        apply_stimulus("lw_after_idle", 1'b0, SZ_WORD, 1'b0, 32'h3004, 32'h0, 32'h1234_BEEF, 1'b0);
        drain("idle");

        // Store then load of the same word on consecutive cycles.
        apply_stimulus("b2b_sw", 1'b1, SZ_WORD, 1'b0, 32'h3000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        apply_stimulus("b2b_lw", 1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0, 32'hA5A5_A5A5, 1'b0);
        drain("b2b");

        // Reset again at clear index 8: the sweep must start over from 0.
        fill_pattern(32'h5A5A_0000);
        reset_pulse("mid_a", 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check_output("mid_ready_low", 32'(req_ready), 32'd0);
        reset_pulse("mid_b", 1'b0);
        measure_clear("mid");
        expect_all_zero("mid_rd");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation still running at 500000, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
